ones_run_reporter: RTL



---
 rtl/ones_run_reporter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ones_run_reporter.sv
// Measures each contiguous high run of the detector flag and queues {saturated, length}
// records in a small first-word-fall-through FIFO drained by a valid/ready handshake.
module ones_run_reporter #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det,
   input  logic             rec_ready,
   output logic             rec_valid,
   output logic [CNT_W-1:0] rec_len,
   output logic             rec_sat,
   output logic             busy,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

   typedef struct packed {
      logic             sat;
      logic [CNT_W-1:0] len;
   } rec_t;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
   logic             run_sat, run_sat_nxt;
   logic             push;
   rec_t             push_rec;

   // ---------------- run tracker ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         run_cnt <= '0;
         run_sat <= 1'b0;
      end else begin
         state   <= state_nxt;
         run_cnt <= run_cnt_nxt;
         run_sat <= run_sat_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      run_cnt_nxt = run_cnt;
      run_sat_nxt = run_sat;
      push        = 1'b0;
      case (state)
         IDLE: begin
            if (det) begin
               state_nxt   = RUN;
               run_cnt_nxt = CNT_ONE;
               run_sat_nxt = 1'b0;
            end
         end
         RUN: begin
            if (det) begin
               // Counter holds at max; the attempted increment marks the record saturated.
               if (run_cnt == CNT_MAX) run_sat_nxt = 1'b1;
               else                    run_cnt_nxt = run_cnt + CNT_ONE;
            end else begin
               push      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign push_rec = '{sat: run_sat, len: run_cnt};

   // ---------------- record FIFO ----------------
   rec_t        mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full, pop, wr_en, drop;
   rec_t        head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && rec_ready;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= push_rec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         if (drop)  overflow <= 1'b1;
      end
   end

   // Outputs decode only flops: no path from det or rec_ready.
   assign head      = mem[rd_ptr[AW-1:0]];
   assign rec_valid = !empty;
   assign rec_len   = head.len;
   assign rec_sat   = head.sat;
   assign busy      = (state == RUN);

endmodule
